// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity selectors, transmitter
// state encoding and the baud counter width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and pulses tick on the last count.
// Holding restart high parks the counter at zero so the next period is full length.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int              CW   = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0]   LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready intake, 5..9 data bits, optional
// odd/even parity, 1 or 2 stop bits, frame timing aligned to the handshake edge.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 10000000,
  parameter int BAUD_RATE = 9600,
  parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || BAUD_DIV < 2) begin : g_bad_params
    $fatal(1, "uart_tx_param: illegal parameter combination");
  end

  localparam int                IDX_W     = 4;
  localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_e             state, state_nx;
  logic [DATA_BITS-1:0]  shift, shift_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic                  par, par_nx;
  logic                  tx_nx;
  logic                  tick;

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state == ST_IDLE),
    .tick    (tick)
  );

  assign tx_ready = (state == ST_IDLE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    shift_nx = shift;
    idx_nx   = idx;
    par_nx   = par;

    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_nx = tx_data;
          par_nx   = (PARITY == PAR_EVEN) ? ^tx_data : ~^tx_data;
          idx_nx   = '0;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          idx_nx   = '0;
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_nx = shift >> 1;
          if (idx == LAST_DATA) begin
            idx_nx   = '0;
            state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          idx_nx   = '0;
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (idx == LAST_STOP) begin
            idx_nx   = '0;
            state_nx = ST_IDLE;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM is heading.
    case (state_nx)
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = shift_nx[0];
      ST_PARITY: tx_nx = par_nx;
      default:   tx_nx = 1'b1;
    endcase
  end

  // NOTE: the shift register is a handful of flops, so it is reset along with
  // the control state; a larger buffer would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shift <= '0;
      idx   <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      shift <= shift_nx;
      idx   <= idx_nx;
      par   <= par_nx;
      tx    <= tx_nx;
      busy  <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2) checked
// every cycle against a frame-bit model plus directed literal expectations.
module tb_uart_tx_param;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 100000;
  localparam int BD        = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] din [4];
  logic [3:0] vld;
  logic [3:0] txl, busyl, rdyl;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst_n(rst_n), .tx_data(din[0][7:0]), .tx_valid(vld[0]),
           .tx_ready(rdyl[0]), .tx(txl[0]), .busy(busyl[0]));
  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst_n(rst_n), .tx_data(din[1][7:0]), .tx_valid(vld[1]),
           .tx_ready(rdyl[1]), .tx(txl[1]), .busy(busyl[1]));
  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst_n(rst_n), .tx_data(din[2][7:0]), .tx_valid(vld[2]),
           .tx_ready(rdyl[2]), .tx(txl[2]), .busy(busyl[2]));
  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u_7n2 (.clk(clk), .rst_n(rst_n), .tx_data(din[3][6:0]), .tx_valid(vld[3]),
           .tx_ready(rdyl[3]), .tx(txl[3]), .busy(busyl[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line bits of one frame, index 0 first on the wire, for configuration cfg.
  function automatic void build(input int cfg, input logic [8:0] d,
                                output logic [15:0] bits, output int n);
    int db   = (cfg == 3) ? 7 : 8;
    int par  = (cfg == 1) ? 2 : (cfg == 2) ? 1 : 0;
    int stop = (cfg == 3) ? 2 : 1;
    int ones = 0;
    int k;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      bits[1+i] = d[i];
      ones += int'(d[i]);
    end
    k = 1 + db;
    if (par != 0) begin
      bits[k] = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      k++;
    end
    n = k + stop;
  endfunction

  // Model: clocks left in the current frame and its bit pattern per instance.
  int          rem [4];
  int          nb  [4];
  logic [15:0] fr  [4];

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] b;
    int          n;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        rem[i] <= 0;
      end else if (rem[i] != 0) begin
        rem[i] <= rem[i] - 1;
      end else if (vld[i]) begin
        build(i, din[i], b, n);
        fr[i]  <= b;
        nb[i]  <= n;
        rem[i] <= n * BD;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic exp_tx;
      exp_tx = (rem[i] == 0) ? 1'b1 : fr[i][(nb[i] * BD - rem[i]) / BD];
      check($sformatf("tx[%0d]", i),       32'(txl[i]),   32'(exp_tx));
      check($sformatf("busy[%0d]", i),     32'(busyl[i]), 32'(rem[i] != 0));
      check($sformatf("tx_ready[%0d]", i), 32'(rdyl[i]),  32'(rem[i] == 0));
    end
  end

  // Sends d on instance i, samples the line mid-bit, returns frame length.
  task automatic run_frame(input int i, input logic [8:0] d, input bit noisy,
                           output int len, output logic [15:0] samp);
    int w = 0;
    int c = 0;
    @(negedge clk);
    din[i] = d;
    vld[i] = 1'b1;
    while (!rdyl[i] && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_send", 32'(rdyl[i]), 32'd1);
    @(posedge clk);
    #1;
    samp = '0;
    while (busyl[i] && c < 160) begin
      if (c % BD == 5) samp[c / BD] = txl[i];
      if (c == 1) vld[i] = 1'b0;
      if (noisy) begin
        din[i] = 9'($urandom);
        vld[i] = (c == 55);
      end
      @(posedge clk);
      #1;
      c++;
    end
    vld[i] = 1'b0;
    len = c;
  endtask

  initial begin
    logic [15:0] b;
    int          n;
    int          len;
    int          w;
    logic [15:0] samp;
    logic        extra;

    vld = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;

    build(0, 9'h0A5, b, n);
    check("model_8n1_bits", 32'(b[9:0]), 32'h34A);
    check("model_8n1_len", n, 10);
    build(1, 9'h007, b, n);
    check("model_8e1_bits", 32'(b[10:0]), 32'h60E);
    build(2, 9'h007, b, n);
    check("model_8o1_bits", 32'(b[10:0]), 32'h40E);
    build(3, 9'h07F, b, n);
    check("model_7n2_bits", 32'(b[9:0]), 32'h3FE);
    check("model_7n2_len", n, 10);

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(txl), 32'hF);
    check("reset_busy", 32'(busyl), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_reset", 32'(rdyl), 32'hF);

    run_frame(0, 9'h0A5, 1'b0, len, samp);
    check("8n1_a5_bits", 32'(samp[9:0]), 32'h34A);
    check("8n1_a5_len", len, 100);

    run_frame(1, 9'h007, 1'b0, len, samp);
    check("8e1_07_bits", 32'(samp[10:0]), 32'h60E);
    check("8e1_07_len", len, 110);

    run_frame(2, 9'h007, 1'b0, len, samp);
    check("8o1_07_bits", 32'(samp[10:0]), 32'h40E);
    check("8o1_07_len", len, 110);

    run_frame(3, 9'h07F, 1'b0, len, samp);
    check("7n2_7f_bits", 32'(samp[9:0]), 32'h3FE);
    check("7n2_7f_len", len, 100);

    // Back-to-back: valid held high across the frame boundary.
    @(negedge clk);
    din[0] = 9'h055;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_first_start", 32'(txl[0]), 32'd0);
    @(negedge clk);
    din[0] = 9'h0AA;
    w = 0;
    while (busyl[0] && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("b2b_first_len", w, 100);
    check("b2b_idle_tx", 32'(txl[0]), 32'd1);
    w = 0;
    while (!busyl[0] && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("b2b_gap", w, 1);
    check("b2b_second_start", 32'(txl[0]), 32'd0);
    vld[0] = 1'b0;
    w = 0;
    while (busyl[0] && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("b2b_second_len", w, 100);

    // Hold-off: data churns and valid pulses mid-frame; latched value wins.
    run_frame(1, 9'h03C, 1'b1, len, samp);
    check("holdoff_bits", 32'(samp[10:0]), 32'h478);
    check("holdoff_len", len, 110);
    extra = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      extra |= busyl[1];
    end
    check("holdoff_no_extra", 32'(extra), 32'd0);

    // Reset mid-frame at clock 37 of a 0x00 frame, while tx is low.
    @(negedge clk);
    din[0] = 9'h000;
    vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (36) @(posedge clk);
    #2;
    check("pre_reset_tx", 32'(txl[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_tx", 32'(txl[0]), 32'd1);
    check("midframe_reset_busy", 32'(busyl[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_midframe_reset", 32'(rdyl[0]), 32'd1);
    run_frame(0, 9'h0A5, 1'b0, len, samp);
    check("post_reset_bits", 32'(samp[9:0]), 32'h34A);
    check("post_reset_len", len, 100);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
